// File: rtl/issue_scoreboard.sv
// Single-slot in-order issue stage with a 32-entry register scoreboard.
// Stalls decode on RAW/WAW hazards and counts hazard-stall cycles.
module issue_scoreboard (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic [5:0]  dec_type,
   input  logic [4:0]  dec_rs0,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rdt,
   output logic        iss_valid,
   input  logic        iss_ready,
   output logic [5:0]  iss_type,
   output logic [4:0]  iss_rdt,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rdt,
   input  logic        flush,
   output logic [31:0] busy,
   output logic [15:0] stall_cnt
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slot_state_t;

   slot_state_t st_reg, st_next;

   logic [31:0] busy_reg, busy_next;
   logic [31:0] eff_busy;
   logic [31:0] wb_clear;
   logic [31:0] dec_set;
   logic [15:0] stall_reg, stall_next;
   logic [5:0]  type_reg, type_next;
   logic [4:0]  rdt_reg, rdt_next;

   logic type_r, type_i, type_s, type_b, type_u, type_j;
   logic use0, use1, wr;
   logic hazard;
   logic accept;
   logic consume;

   assign {type_r, type_i, type_s, type_b, type_u, type_j} = dec_type;

   // Operand usage is an OR of the type bits, so non-one-hot encodings are legal.
   assign use0 = type_r | type_i | type_s | type_b;
   assign use1 = type_r | type_s | type_b;
   assign wr   = (type_r | type_i | type_u | type_j) & (dec_rdt != 5'd0);

   // Per-register one-hot decode of the writeback release and the decode claim.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi = gi + 1) begin : g_bit
         assign wb_clear[gi] = wb_valid && (wb_rdt == gi[4:0]);
         assign dec_set[gi]  = accept && wr && (dec_rdt == gi[4:0]);
         assign eff_busy[gi] = busy_reg[gi] & ~wb_clear[gi];

         if (gi == 0) begin : g_zero
            assign busy_next[gi] = 1'b0;
         end else begin : g_reg
            // Flush dominates; a fresh claim beats a release of the same register.
            assign busy_next[gi] = flush       ? 1'b0 :
                                   dec_set[gi] ? 1'b1 :
                                   wb_clear[gi] ? 1'b0 :
                                   busy_reg[gi];
         end
      end
   endgenerate

   assign hazard = (use0 & eff_busy[dec_rs0]) |
                   (use1 & eff_busy[dec_rs1]) |
                   (wr   & eff_busy[dec_rdt]);

   assign iss_valid = (st_reg == FULL);
   assign consume   = iss_valid & iss_ready;
   assign dec_ready = ~flush & ~hazard & (~iss_valid | iss_ready);
   assign accept    = dec_valid & dec_ready;

   always_comb begin
      st_next   = st_reg;
      type_next = type_reg;
      rdt_next  = rdt_reg;
      if (flush) begin
         st_next = EMPTY;
      end else begin
         case (st_reg)
            EMPTY: begin
               if (accept) begin
                  st_next = FULL;
               end
            end
            FULL: begin
               if (consume && !accept) begin
                  st_next = EMPTY;
               end
            end
            default: st_next = EMPTY;
         endcase
      end
      if (accept) begin
         type_next = dec_type;
         rdt_next  = dec_rdt;
      end
   end

   always_comb begin
      stall_next = stall_reg;
      if (dec_valid && hazard && !flush && (stall_reg != 16'hFFFF)) begin
         stall_next = stall_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_reg    <= EMPTY;
         type_reg  <= 6'd0;
         rdt_reg   <= 5'd0;
         busy_reg  <= 32'd0;
         stall_reg <= 16'd0;
      end else begin
         st_reg    <= st_next;
         type_reg  <= type_next;
         rdt_reg   <= rdt_next;
         busy_reg  <= busy_next;
         stall_reg <= stall_next;
      end
   end

   assign iss_type  = type_reg;
   assign iss_rdt   = rdt_reg;
   assign busy      = busy_reg;
   assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Table-driven check of issue_scoreboard with an issue-order scoreboard queue,
// plus hand-written sequences for flush, saturation and asynchronous reset.
module tb_issue_scoreboard;

   localparam logic [5:0] T_R = 6'b100000;
   localparam logic [5:0] T_I = 6'b010000;
   localparam logic [5:0] T_S = 6'b001000;
   localparam logic [5:0] T_B = 6'b000100;
   localparam logic [5:0] T_U = 6'b000010;
   localparam logic [5:0] T_J = 6'b000001;

   logic        clk;
   logic        rst_n;
   logic        dec_valid;
   logic        dec_ready;
   logic [5:0]  dec_type;
   logic [4:0]  dec_rs0, dec_rs1, dec_rdt;
   logic        iss_valid;
   logic        iss_ready;
   logic [5:0]  iss_type;
   logic [4:0]  iss_rdt;
   logic        wb_valid;
   logic [4:0]  wb_rdt;
   logic        flush;
   logic [31:0] busy;
   logic [15:0] stall_cnt;

   issue_scoreboard dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dec_valid (dec_valid),
      .dec_ready (dec_ready),
      .dec_type  (dec_type),
      .dec_rs0   (dec_rs0),
      .dec_rs1   (dec_rs1),
      .dec_rdt   (dec_rdt),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_type  (iss_type),
      .iss_rdt   (iss_rdt),
      .wb_valid  (wb_valid),
      .wb_rdt    (wb_rdt),
      .flush     (flush),
      .busy      (busy),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [5:0]  typ;
      logic [4:0]  rs0, rs1, rdt;
      logic        ir;
      logic        wbv;
      logic [4:0]  wbr;
      logic        fl;
      logic        exp_ready;
      logic        exp_ivalid;
      logic [31:0] exp_busy;
      logic [15:0] exp_stall;
   } vec_t;

   typedef struct packed {
      logic [5:0] typ;
      logic [4:0] rdt;
   } slot_t;

   slot_t sb_q[$];
   vec_t  tbl[18];
   int    n_checks = 0;
   int    n_errors = 0;
   int    n_vec    = 0;

   function automatic vec_t mk(logic dv, logic [5:0] typ, logic [4:0] rs0, logic [4:0] rs1,
                               logic [4:0] rdt, logic ir, logic wbv, logic [4:0] wbr, logic fl,
                               logic er, logic eiv, logic [31:0] eb, logic [15:0] es);
      vec_t v;
      v.dv = dv; v.typ = typ; v.rs0 = rs0; v.rs1 = rs1; v.rdt = rdt;
      v.ir = ir; v.wbv = wbv; v.wbr = wbr; v.fl = fl;
      v.exp_ready = er; v.exp_ivalid = eiv; v.exp_busy = eb; v.exp_stall = es;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge: drive, check combinational ready and the
   // slot being consumed, then check registered state after the next edge.
   task automatic apply(input vec_t v);
      slot_t s;
      dec_valid = v.dv; dec_type = v.typ; dec_rs0 = v.rs0; dec_rs1 = v.rs1; dec_rdt = v.rdt;
      iss_ready = v.ir; wb_valid = v.wbv; wb_rdt = v.wbr; flush = v.fl;
      #1;
      chk($sformatf("dec_ready[%0d]", n_vec), {31'd0, dec_ready}, {31'd0, v.exp_ready});
      if (iss_valid && iss_ready) begin
         if (sb_q.size() == 0) begin
            chk($sformatf("unexpected_issue[%0d]", n_vec), {31'd0, iss_valid}, 32'd0);
         end else begin
            s = sb_q.pop_front();
            chk($sformatf("iss_type[%0d]", n_vec), {26'd0, iss_type}, {26'd0, s.typ});
            chk($sformatf("iss_rdt[%0d]", n_vec), {27'd0, iss_rdt}, {27'd0, s.rdt});
         end
      end
      if (v.dv && v.exp_ready) begin
         s.typ = v.typ;
         s.rdt = v.rdt;
         sb_q.push_back(s);
      end
      @(posedge clk);
      #1;
      if (v.fl) sb_q.delete();
      chk($sformatf("iss_valid[%0d]", n_vec), {31'd0, iss_valid}, {31'd0, v.exp_ivalid});
      chk($sformatf("busy[%0d]", n_vec), busy, v.exp_busy);
      chk($sformatf("stall_cnt[%0d]", n_vec), {16'd0, stall_cnt}, {16'd0, v.exp_stall});
      $display("vec %0d: dv=%0b type=%b rs0=%0d rs1=%0d rdt=%0d ir=%0b wb=%0b/%0d fl=%0b -> busy=%h stall=%0d",
               n_vec, v.dv, v.typ, v.rs0, v.rs1, v.rdt, v.ir, v.wbv, v.wbr, v.fl, busy, stall_cnt);
      n_vec++;
   endtask

   initial begin
      logic [31:0] exp_b;
      logic [15:0] s0;

      //            dv typ  rs0 rs1 rdt ir wbv wbr fl  rdy iv busy          stall
      tbl[0]  = mk(1, T_R,  1,  2,  5,  1, 0,  0,  0,  1,  1, 32'h0000_0020, 0);
      tbl[1]  = mk(1, T_I,  5,  0,  3,  1, 0,  0,  0,  0,  0, 32'h0000_0020, 1);
      tbl[2]  = mk(1, T_I,  5,  0,  3,  1, 0,  0,  0,  0,  0, 32'h0000_0020, 2);
      tbl[3]  = mk(1, T_I,  5,  0,  3,  1, 0,  0,  0,  0,  0, 32'h0000_0020, 3);
      tbl[4]  = mk(1, T_I,  5,  0,  3,  1, 1,  5,  0,  1,  1, 32'h0000_0008, 3);
      tbl[5]  = mk(1, T_J,  0,  0,  7,  1, 0,  0,  0,  1,  1, 32'h0000_0088, 3);
      tbl[6]  = mk(1, T_S,  1,  7,  0,  1, 0,  0,  0,  0,  0, 32'h0000_0088, 4);
      tbl[7]  = mk(1, T_B,  1,  2,  7,  1, 0,  0,  0,  1,  1, 32'h0000_0088, 4);
      tbl[8]  = mk(1, T_U,  7,  7,  9,  1, 0,  0,  0,  1,  1, 32'h0000_0288, 4);
      tbl[9]  = mk(1, T_U,  0,  0,  9,  1, 1,  9,  0,  1,  1, 32'h0000_0288, 4);
      tbl[10] = mk(1, T_U,  0,  0,  0,  1, 0,  0,  0,  1,  1, 32'h0000_0288, 4);
      tbl[11] = mk(1, T_R,  1,  2, 10,  0, 0,  0,  0,  0,  1, 32'h0000_0288, 4);
      tbl[12] = mk(0, T_R,  1,  2, 10,  0, 0,  0,  0,  0,  1, 32'h0000_0288, 4);
      tbl[13] = mk(0, T_R,  1,  2, 10,  1, 0,  0,  0,  1,  0, 32'h0000_0288, 4);
      tbl[14] = mk(0, 6'd0, 0,  0,  0,  1, 1,  0,  0,  1,  0, 32'h0000_0288, 4);
      tbl[15] = mk(0, 6'd0, 0,  0,  0,  1, 1,  4,  0,  1,  0, 32'h0000_0288, 4);
      tbl[16] = mk(0, 6'd0, 0,  0,  0,  1, 1,  3,  0,  1,  0, 32'h0000_0280, 4);
      tbl[17] = mk(1, T_R,  0,  0,  9,  1, 0,  0,  0,  0,  0, 32'h0000_0280, 5);

      rst_n = 1'b0; dec_valid = 1'b0; dec_type = 6'd0; dec_rs0 = 5'd0; dec_rs1 = 5'd0;
      dec_rdt = 5'd0; iss_ready = 1'b0; wb_valid = 1'b0; wb_rdt = 5'd0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_iss_valid", {31'd0, iss_valid}, 32'd0);
      chk("reset_iss_type", {26'd0, iss_type}, 32'd0);
      chk("reset_busy", busy, 32'd0);
      chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) apply(tbl[i]);

      // Fill every remaining register 1..15 so the scoreboard reads 32'hFFFE.
      exp_b = 32'h0000_0280;
      for (int k = 1; k < 16; k++) begin
         if (k != 7 && k != 9) begin
            exp_b = exp_b | (32'd1 << k);
            apply(mk(1, T_R, 0, 0, 5'(k), 1, 0, 0, 0, 1, 1, exp_b, 5));
         end
      end
      chk("fill_busy", busy, 32'h0000_FFFE);

      // Flush with a hazarding instruction and a writeback: all dropped, no stall counted.
      apply(mk(1, T_R, 1, 0, 20, 1, 1, 7, 1, 0, 0, 32'd0, 5));
      apply(mk(1, T_R, 2, 3, 1, 0, 0, 0, 0, 1, 1, 32'h0000_0002, 5));

      // Saturation: hold a RAW hazard on x1 with the slot stalled downstream.
      s0 = 16'd5;
      dec_valid = 1'b1; dec_type = T_I; dec_rs0 = 5'd1; dec_rs1 = 5'd0; dec_rdt = 5'd0;
      iss_ready = 1'b0; wb_valid = 1'b0; flush = 1'b0;
      repeat (int'(16'hFFFE - s0)) @(posedge clk);
      #1;
      chk("stall_fffe", {16'd0, stall_cnt}, 32'h0000_FFFE);
      @(posedge clk);
      #1;
      chk("stall_ffff", {16'd0, stall_cnt}, 32'h0000_FFFF);
      repeat (5) @(posedge clk);
      #1;
      chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
      $display("saturation burst: stall_cnt=%h iss_valid=%0b", stall_cnt, iss_valid);

      // Asynchronous reset mid-burst, sampled between clock edges.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_iss_valid", {31'd0, iss_valid}, 32'd0);
      chk("async_iss_type", {26'd0, iss_type}, 32'd0);
      chk("async_iss_rdt", {27'd0, iss_rdt}, 32'd0);
      chk("async_busy", busy, 32'd0);
      chk("async_stall", {16'd0, stall_cnt}, 32'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply(mk(1, T_R, 1, 3, 2, 1, 0, 0, 0, 1, 1, 32'h0000_0004, 0));
      apply(mk(0, 6'd0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h0000_0004, 0));
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
